// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface emulator: SPI mode-0 device end, oversampled on iclk.
// Implements 0x0A write / 0x0B read with address auto-increment, ID registers,
// coherent X/Y/Z shadow snapshot per transaction and the POWER_CTL register.
module adxl362_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2,
  parameter logic [7:0]  REVID       = 8'h01
) (
  input  logic        iclk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [15:0] x_sample,
  input  logic [15:0] y_sample,
  input  logic [15:0] z_sample,
  output logic [7:0]  power_ctl,
  output logic        measure,
  output logic        reg_wr,
  output logic [7:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_e;

  localparam logic [7:0] CMD_WRITE   = 8'h0A;
  localparam logic [7:0] CMD_READ    = 8'h0B;
  localparam logic [7:0] ADDR_PCTL   = 8'h2D;
  localparam logic [7:0] ADDR_SRST   = 8'h1F;
  localparam logic [7:0] SRST_KEY    = 8'h52;

  // Synchronizer and edge-detect state
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   cs_armed_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic rise_p;
  logic fall_p;
  logic cs_fall_p;
  logic cs_rise_p;
  logic byte_done;
  logic [7:0] rx_byte;

  // Protocol state
  state_e      state_q,       state_d;
  logic        mode_wr_q,     mode_wr_d;
  logic [7:0]  addr_q,        addr_d;
  logic [6:0]  rx_sh_q,       rx_sh_d;
  logic [2:0]  bit_cnt_q,     bit_cnt_d;
  logic [7:0]  tx_sh_q,       tx_sh_d;
  logic        miso_q,        miso_d;
  logic        miso_oe_q,     miso_oe_d;
  logic [15:0] x_sh_q,        x_sh_d;
  logic [15:0] y_sh_q,        y_sh_d;
  logic [15:0] z_sh_q,        z_sh_d;
  logic [7:0]  power_ctl_q,   power_ctl_d;
  logic        measure_q,     measure_d;
  logic        reg_wr_q,      reg_wr_d;
  logic [7:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [7:0]  reg_wr_data_q, reg_wr_data_d;

  // Register read map; unmapped addresses read as zero.
  function automatic logic [7:0] read_reg(
    input logic [7:0]  a,
    input logic [15:0] xs,
    input logic [15:0] ys,
    input logic [15:0] zs,
    input logic [7:0]  pc
  );
    logic [7:0] r;
    case (a)
      8'h00:   r = DEVID_AD;
      8'h01:   r = DEVID_MST;
      8'h02:   r = PARTID;
      8'h03:   r = REVID;
      8'h0E:   r = xs[7:0];
      8'h0F:   r = xs[15:8];
      8'h10:   r = ys[7:0];
      8'h11:   r = ys[15:8];
      8'h12:   r = zs[7:0];
      8'h13:   r = zs[15:8];
      8'h2D:   r = pc;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign rise_p    = sclk_s & ~sclk_prev_q;
  assign fall_p    = ~sclk_s & sclk_prev_q;
  // A cs falling edge only counts once cs has been seen high after reset, so a
  // transaction already in progress when rst releases is ignored to its end.
  assign cs_fall_p = cs_prev_q & ~cs_s & cs_armed_q;
  assign cs_rise_p = ~cs_prev_q & cs_s;
  assign rx_byte   = {rx_sh_q, mosi_s};
  assign byte_done = (state_q != S_IDLE) & ~cs_s & rise_p & (bit_cnt_q == 3'd7);

  // Pin synchronizers, delayed copies for edge detection and the post-reset cs arm.
  always_ff @(posedge iclk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      cs_armed_q  <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      end else begin
        sclk_sync_q <= sclk;
        cs_sync_q   <= cs;
        mosi_sync_q <= mosi;
        settle_q    <= 1'b1;
      end
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      // settle_q top bit means the cs tap now holds a real post-reset sample
      cs_armed_q  <= cs_armed_q | (settle_q[SYNC_STAGES-1] & cs_s);
    end
  end

  // Bit engine, protocol FSM, register writes and snapshot next-state logic.
  always_comb begin
    state_d       = state_q;
    mode_wr_d     = mode_wr_q;
    addr_d        = addr_q;
    rx_sh_d       = rx_sh_q;
    bit_cnt_d     = bit_cnt_q;
    tx_sh_d       = tx_sh_q;
    miso_d        = miso_q;
    miso_oe_d     = ~cs_s;
    x_sh_d        = x_sh_q;
    y_sh_d        = y_sh_q;
    z_sh_d        = z_sh_q;
    power_ctl_d   = power_ctl_q;
    reg_wr_d      = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;

    // Snapshot the samples at the start of each transaction.
    if (cs_fall_p) begin
      x_sh_d = x_sample;
      y_sh_d = y_sample;
      z_sh_d = z_sample;
    end else begin
      x_sh_d = x_sh_q;
      y_sh_d = y_sh_q;
      z_sh_d = z_sh_q;
    end

    // Shift in on sclk rise, shift out on sclk fall; miso held low otherwise.
    if ((state_q != S_IDLE) && !cs_s) begin
      if (rise_p) begin
        rx_sh_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else if (fall_p) begin
        miso_d  = tx_sh_q[7];
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end else begin
        miso_d = miso_q;
      end
    end else begin
      miso_d = 1'b0;
    end

    if (cs_rise_p) begin
      // End of transaction wins over a coincident byte_done; partial byte dropped.
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      rx_sh_d   = 7'd0;
      tx_sh_d   = 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall_p) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            rx_sh_d   = 7'd0;
            tx_sh_d   = 8'h00;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          if (byte_done) begin
            if (rx_byte == CMD_WRITE) begin
              mode_wr_d = 1'b1;
              state_d   = S_ADDR;
            end else if (rx_byte == CMD_READ) begin
              mode_wr_d = 1'b0;
              state_d   = S_ADDR;
            end else begin
              state_d = S_IGNORE;
            end
          end else begin
            state_d = S_CMD;
          end
        end
        S_ADDR: begin
          if (byte_done) begin
            if (mode_wr_q) begin
              addr_d  = rx_byte;
              state_d = S_WDATA;
            end else begin
              tx_sh_d = read_reg(rx_byte, x_sh_q, y_sh_q, z_sh_q, power_ctl_q);
              addr_d  = rx_byte + 8'd1;
              state_d = S_RDATA;
            end
          end else begin
            state_d = S_ADDR;
          end
        end
        S_WDATA: begin
          if (byte_done) begin
            // Only POWER_CTL and the soft-reset key are accepted writes.
            if (addr_q == ADDR_PCTL) begin
              power_ctl_d   = rx_byte;
              reg_wr_d      = 1'b1;
              reg_wr_addr_d = addr_q;
              reg_wr_data_d = rx_byte;
            end else if ((addr_q == ADDR_SRST) && (rx_byte == SRST_KEY)) begin
              power_ctl_d   = 8'h00;
              reg_wr_d      = 1'b1;
              reg_wr_addr_d = addr_q;
              reg_wr_data_d = rx_byte;
            end else begin
              reg_wr_d = 1'b0;
            end
            addr_d = addr_q + 8'd1;
          end else begin
            state_d = S_WDATA;
          end
        end
        S_RDATA: begin
          if (byte_done) begin
            tx_sh_d = read_reg(addr_q, x_sh_q, y_sh_q, z_sh_q, power_ctl_q);
            addr_d  = addr_q + 8'd1;
          end else begin
            state_d = S_RDATA;
          end
        end
        S_IGNORE: begin
          tx_sh_d = 8'h00;
          state_d = S_IGNORE;
        end
        default: begin
          state_d = S_IDLE;
          tx_sh_d = 8'h00;
        end
      endcase
    end

    measure_d = (power_ctl_d[1:0] == 2'b10);
  end

  // Protocol state, registered outputs and shadows.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_wr_q     <= 1'b0;
      addr_q        <= 8'h00;
      rx_sh_q       <= 7'd0;
      bit_cnt_q     <= 3'd0;
      tx_sh_q       <= 8'h00;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      x_sh_q        <= 16'h0000;
      y_sh_q        <= 16'h0000;
      z_sh_q        <= 16'h0000;
      power_ctl_q   <= 8'h00;
      measure_q     <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= 8'h00;
      reg_wr_data_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      mode_wr_q     <= mode_wr_d;
      addr_q        <= addr_d;
      rx_sh_q       <= rx_sh_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_sh_q       <= tx_sh_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      x_sh_q        <= x_sh_d;
      y_sh_q        <= y_sh_d;
      z_sh_q        <= z_sh_d;
      power_ctl_q   <= power_ctl_d;
      measure_q     <= measure_d;
      reg_wr_q      <= reg_wr_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign power_ctl   = power_ctl_q;
  assign measure     = measure_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Self-checking bench: mode-0 SPI master model driving directed and random
// transactions, checked against a register-image reference model.
`timescale 1ns/1ps
module tb_adxl362_spi_responder;

  localparam int HALF = 50;   // sclk half period; iclk period is 10 ns

  logic        iclk = 1'b0;
  logic        rst, sclk, cs, mosi;
  logic        miso, miso_oe, measure, reg_wr;
  logic [15:0] x_sample, y_sample, z_sample;
  logic [7:0]  power_ctl, reg_wr_addr, reg_wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_seen = 0;

  logic [7:0] tx_buf  [16];
  logic [7:0] rx_buf  [16];
  logic [7:0] exp_buf [16];
  logic [7:0] img     [256];

  // reference model state
  logic [7:0] m_pctl, m_wa, m_wd;
  int         m_wr;

  adxl362_spi_responder dut (
    .iclk(iclk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .x_sample(x_sample), .y_sample(y_sample), .z_sample(z_sample),
    .power_ctl(power_ctl), .measure(measure), .reg_wr(reg_wr),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  always #5 iclk = ~iclk;

  // count every iclk cycle in which the write strobe is high
  always @(negedge iclk) if (reg_wr === 1'b1) wr_seen++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sx12();
    logic [11:0] v;
    v = 12'($urandom);
    return {{4{v[11]}}, v};
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h2D) begin
      m_pctl = d; m_wa = a; m_wd = d; m_wr++;
    end else if (a == 8'h1F && d == 8'h52) begin
      m_pctl = 8'h00; m_wa = a; m_wd = d; m_wr++;
    end
  endtask

  // Mode-0 master: mosi set while sclk low, miso sampled at rising sclk.
  task automatic spi_run(input string tag, input int nbytes, input int last_bits,
                         input int chg_idx, input logic [15:0] chg_val, input int rst_idx);
    int nb;
    cs = 1'b0;
    #150;
    for (int b = 0; b < nbytes; b++) begin
      nb = (b == nbytes - 1) ? last_bits : 8;
      if (b == rst_idx) begin
        rst = 1'b1;
        #30;
        check_eq({tag, ".rst_oe"}, 32'(miso_oe), 32'd0);
        check_eq({tag, ".rst_miso"}, 32'(miso), 32'd0);
        #20;
        rst = 1'b0;
      end
      rx_buf[b] = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
        mosi = tx_buf[b][i];
        #HALF;
        sclk = 1'b1;
        rx_buf[b][i] = miso;
        if (b == 0 && i == 7) check_eq({tag, ".oe_on"}, 32'(miso_oe), 32'd1);
        #HALF;
        sclk = 1'b0;
      end
      if (b == chg_idx) x_sample = chg_val;
    end
    #HALF;
    cs   = 1'b1;
    mosi = 1'b0;
    #150;
  endtask

  // Model the transaction from a register image, run it, compare everything.
  task automatic run_txn(input string tag, input int nbytes, input int last_bits,
                         input int chg_idx, input logic [15:0] chg_val, input int rst_idx);
    int nfull, nproc;
    logic [7:0] a, cmd;
    nfull = (last_bits == 8) ? nbytes : nbytes - 1;
    nproc = (rst_idx < nfull) ? rst_idx : nfull;
    foreach (img[i]) img[i] = 8'h00;
    img[8'h00] = 8'hAD; img[8'h01] = 8'h1D; img[8'h02] = 8'hF2; img[8'h03] = 8'h01;
    img[8'h0E] = x_sample[7:0]; img[8'h0F] = x_sample[15:8];
    img[8'h10] = y_sample[7:0]; img[8'h11] = y_sample[15:8];
    img[8'h12] = z_sample[7:0]; img[8'h13] = z_sample[15:8];
    img[8'h2D] = m_pctl;
    cmd = tx_buf[0];
    a   = tx_buf[1];
    for (int b = 0; b < 16; b++) exp_buf[b] = 8'h00;
    for (int b = 2; b < nproc; b++) begin
      if (cmd == 8'h0B) exp_buf[b] = img[a];
      else if (cmd == 8'h0A) m_write(a, tx_buf[b]);
      a = a + 8'd1;
    end
    if (rst_idx < nbytes) begin
      m_pctl = 8'h00; m_wa = 8'h00; m_wd = 8'h00;
    end
    spi_run(tag, nbytes, last_bits, chg_idx, chg_val, rst_idx);
    for (int b = 0; b < nfull; b++)
      check_eq($sformatf("%s.miso_byte%0d", tag, b), 32'(rx_buf[b]), 32'(exp_buf[b]));
    check_eq({tag, ".power_ctl"}, 32'(power_ctl), 32'(m_pctl));
    check_eq({tag, ".measure"}, 32'(measure), 32'(m_pctl[1:0] == 2'b10));
    check_eq({tag, ".wr_addr"}, 32'(reg_wr_addr), 32'(m_wa));
    check_eq({tag, ".wr_data"}, 32'(reg_wr_data), 32'(m_wd));
    check_eq({tag, ".wr_cycles"}, 32'(wr_seen), 32'(m_wr));
    check_eq({tag, ".idle_miso"}, 32'(miso), 32'd0);
    check_eq({tag, ".idle_oe"}, 32'(miso_oe), 32'd0);
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
    tx_buf[3] = b3; tx_buf[4] = b4; tx_buf[5] = b5;
  endtask

  initial begin
    int nbytes, last_bits, chg_idx;
    logic [7:0] cmd, addr;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    x_sample = 16'h0000; y_sample = 16'h0000; z_sample = 16'h0000;
    m_pctl = 8'h00; m_wa = 8'h00; m_wd = 8'h00; m_wr = 0;
    for (int b = 0; b < 16; b++) tx_buf[b] = 8'h00;
    #100;
    rst = 1'b0;
    #100;
    check_eq("reset.miso", 32'(miso), 32'd0);
    check_eq("reset.miso_oe", 32'(miso_oe), 32'd0);
    check_eq("reset.power_ctl", 32'(power_ctl), 32'h00);
    check_eq("reset.measure", 32'(measure), 32'd0);
    check_eq("reset.reg_wr", 32'(reg_wr), 32'd0);
    check_eq("reset.wr_addr", 32'(reg_wr_addr), 32'h00);
    check_eq("reset.wr_data", 32'(reg_wr_data), 32'h00);

    // power-up write
    set_tx(8'h0A, 8'h2D, 8'h02, 8'h00, 8'h00, 8'h00);
    run_txn("pwr", 3, 8, -1, 16'h0, 99);
    check_eq("pwr.measure_on", 32'(measure), 32'd1);

    // XY burst
    x_sample = 16'h0123; y_sample = 16'hFF80;
    set_tx(8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("xy", 6, 8, -1, 16'h0, 99);
    check_eq("xy.lit_xl", 32'(rx_buf[2]), 32'h23);
    check_eq("xy.lit_yh", 32'(rx_buf[5]), 32'hFF);

    // ID read and address wrap
    set_tx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("id", 6, 8, -1, 16'h0, 99);
    set_tx(8'h0B, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("wrap", 4, 8, -1, 16'h0, 99);
    check_eq("wrap.lit_ad", 32'(rx_buf[3]), 32'hAD);

    // snapshot coherence: change X after the X_L byte
    x_sample = 16'h0123;
    set_tx(8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("snap1", 4, 8, 2, 16'h0456, 99);
    check_eq("snap1.lit_xh", 32'(rx_buf[3]), 32'h01);
    run_txn("snap2", 4, 8, -1, 16'h0, 99);
    check_eq("snap2.lit_xl", 32'(rx_buf[2]), 32'h56);

    // abort mid-address, then readback, then bad command
    set_tx(8'h0A, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("abort", 2, 5, -1, 16'h0, 99);
    set_tx(8'h0B, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("rdpc", 3, 8, -1, 16'h0, 99);
    set_tx(8'h0D, 8'h2D, 8'h55, 8'hFF, 8'h00, 8'h00);
    run_txn("badcmd", 4, 8, -1, 16'h0, 99);

    // soft reset key and a rejected soft-reset value
    set_tx(8'h0A, 8'h2D, 8'h02, 8'h00, 8'h00, 8'h00);
    run_txn("pc2", 3, 8, -1, 16'h0, 99);
    set_tx(8'h0A, 8'h1F, 8'h52, 8'h00, 8'h00, 8'h00);
    run_txn("srst", 3, 8, -1, 16'h0, 99);
    set_tx(8'h0A, 8'h1F, 8'h11, 8'h00, 8'h00, 8'h00);
    run_txn("srst_bad", 3, 8, -1, 16'h0, 99);

    // rst during the third read byte
    set_tx(8'h0A, 8'h2D, 8'h02, 8'h00, 8'h00, 8'h00);
    run_txn("pc2b", 3, 8, -1, 16'h0, 99);
    set_tx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("rst_mid", 6, 8, -1, 16'h0, 4);
    set_tx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    run_txn("after_rst", 4, 8, -1, 16'h0, 99);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: cmd = 8'h0B;
        4, 5, 6, 7: cmd = 8'h0A;
        default: begin
          cmd = 8'($urandom);
          if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h00;
        end
      endcase
      case ($urandom_range(0, 5))
        0:       addr = 8'($urandom_range(0, 3));
        1:       addr = 8'h0E + 8'($urandom_range(0, 5));
        2:       addr = 8'h2D;
        3:       addr = 8'h1F;
        4:       addr = 8'hFE + 8'($urandom_range(0, 1));
        default: addr = 8'($urandom);
      endcase
      tx_buf[0] = cmd;
      tx_buf[1] = addr;
      for (int b = 2; b < 16; b++) begin
        tx_buf[b] = 8'($urandom);
        if ($urandom_range(0, 1) == 0) tx_buf[b] = 8'h52;
      end
      x_sample = sx12(); y_sample = sx12(); z_sample = sx12();
      nbytes    = $urandom_range(1, 6);
      last_bits = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 8;
      chg_idx   = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 5) : -1;
      run_txn($sformatf("rnd%0d", t), nbytes, last_bits, chg_idx, sx12(), 99);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_responder.md
# adxl362_spi_responder

SPI mode-0 responder that emulates the ADXL362 accelerometer's register interface in FPGA fabric. It is the device end of the bus that our accelerometer reader drives. It lets the shot-simulator reader be exercised in hardware loopback, or fed from recorded or synthetic motion, without the physical sensor. It implements the 0x0A write / 0x0B read command set with address auto-increment. All SPI pins are oversampled on the fast system clock.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk/cs/mosi (≥2)
- DEVID_AD, 8'hAD, value returned at 0x00
- DEVID_MST, 8'h1D, value returned at 0x01
- PARTID, 8'hF2, value returned at 0x02
- REVID, 8'h01, value returned at 0x03

Ports:
- iclk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock from master, asynchronous to iclk
- cs  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- miso_oe  out  1  1 while synchronized cs is low (pad tri-state enable)
- x_sample, y_sample, z_sample  in  16 each  signed 12-bit sample, sign-extended to 16; {H,L} byte order
- power_ctl  out  8  POWER_CTL register (0x2D)
- measure  out  1  power_ctl[1:0] == 2'b10
- reg_wr  out  1  one-cycle strobe per accepted register write
- reg_wr_addr  out  8  address of the last accepted write
- reg_wr_data  out  8  data of the last accepted write

## Operation
- Synchronizers: sclk, cs and mosi each pass through SYNC_STAGES flops. Edge detectors on the synchronized sclk/cs produce rise_p, fall_p, cs_fall_p and cs_rise_p.
- Snapshot: on cs_fall_p, x/y/z_sample are latched into shadow registers. Reads of 0x0E–0x13 return X_L, X_H, Y_L, Y_H, Z_L, Z_H from the shadow, so a burst is always coherent.
- Bit engine:
  - While cs is low, each rise_p shifts synchronized mosi into rx_sh (MSB first) and increments bit_cnt[2:0].
  - byte_done = rise_p with bit_cnt == 7.
  - On each fall_p, miso <= tx_sh[7] and tx_sh shifts left by one.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
  - IDLE: cs high. On cs_fall_p, clear bit_cnt and tx_sh, go to CMD.
  - CMD, on byte_done: 0x0A → ADDR (mode write); 0x0B → ADDR (mode read); any other value → IGNORE.
  - ADDR, on byte_done: latch addr. Mode write → WDATA. Mode read → load tx_sh with reg[addr], then addr+1, go to RDATA.
  - WDATA, on byte_done: perform write at addr, then addr+1.
  - RDATA, on byte_done: load tx_sh with reg[addr], then addr+1. Received byte is ignored.
  - IGNORE: hold until cs rises. tx_sh = 0.
  - Any state, on cs_rise_p: go to IDLE and discard any partial byte. cs_rise_p has priority over a simultaneous byte_done.
- Address handling: addr is 8 bits and wraps 0xFF→0x00.
- Read map:
  - 0x00–0x03 return the ID parameters.
  - 0x0E–0x13 return the shadow bytes.
  - 0x2D returns power_ctl.
  - All other addresses return 0x00.
- Write map:
  - 0x2D: power_ctl <= data.
  - 0x1F with data 0x52 (soft reset): power_ctl <= 0.
  - Every other write, including 0x1F with any other value, is ignored: no strobe.
  - An accepted write pulses reg_wr and updates reg_wr_addr/reg_wr_data.
- miso is 0 during the CMD and ADDR bytes, during IGNORE, and while cs is high.

## Timing
- Reset values: miso 0, miso_oe 0, power_ctl 0x00, measure 0, reg_wr 0, reg_wr_addr 0, reg_wr_data 0. State IDLE, shadows 0, synchronizer flops 1 for cs and 0 for sclk/mosi.
- rst asserted mid-transaction: the above reset values apply on the next edge. While cs stays low after rst releases, the responder stays in IDLE (no cs_fall_p) and treats the remainder of that transaction as ignored.
- miso changes exactly SYNC_STAGES+1 iclk cycles after a sclk falling edge.
- Clock ratio: requires f_iclk ≥ 2·(SYNC_STAGES+2)·f_sclk, i.e. ≥8× for the default SYNC_STAGES.
- Read data: bit 7 of each read byte appears on the fall immediately after the 8th rise of the preceding byte. With the master's continuous mode-0 sclk, the byte stream is gap-free.
- Writes: reg_wr is high for exactly one iclk, on the edge after byte_done. power_ctl and measure update on that same edge.
- Snapshot: taken on the iclk edge after cs_fall_p. Sample changes after that edge are not visible until the next transaction.

## Test plan
- Power-up write: after reset, master writes 0A 2D 02 → reg_wr pulses once; reg_wr_addr = 0x2D, reg_wr_data = 0x02; power_ctl = 0x02; measure = 1.
- XY burst: x_sample = 0x0123, y_sample = 0xFF80; master sends 0B 0E 00 00 00 00 → miso bytes 23 01 80 FF during the four data bytes; 00 during cmd/addr.
- ID read with wrap: read 0B 00 + 4 bytes → AD 1D F2 01. A read starting at 0xFF returns 00 then AD (wrap to 0x00).
- Snapshot coherence: set x_sample = 0x0123, start an X/Y read, change x_sample to 0x0456 after the X_L byte → X_H byte reads 01. The next transaction returns 56 04.
- Abort and bad command: deassert cs after 5 bits of the address byte → no write, FSM returns to IDLE. A following 0B 2D 00 returns power_ctl. A command byte 0x0D → miso 0 for the whole transaction and no reg_wr.
- Soft reset and rst: with power_ctl = 0x02, write 0A 1F 52 → power_ctl = 0, measure = 0. Write 0A 1F 11 → no reg_wr. Assert rst during the 3rd read byte → all outputs return to reset values and miso stays 0 until cs is toggled.
